gol_grid_scanner: RTL and testbench

// - Consumer side of the Game-of-Life generation register: takes the 64-bit grid

---
 rtl/gol_grid_scanner.sv | 138 +++++++++++++
 tb/tb_gol_grid_scanner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/gol_grid_scanner.sv
// Game-of-Life grid scanner: latches a generation at frame boundaries and drives it row by row onto an LED matrix.
// Optional ROW_BLANK_EN inserts BLANK_CYCLES dark clocks after every row (anti-ghosting).
module gol_grid_scanner #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int DWELL        = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [ROWS*COLS-1:0] grid_in,
    input  logic                 grid_valid,
    output logic                 grid_ack,
    output logic [ROWS-1:0]      row_sel,
    output logic [COLS-1:0]      col_data,
    output logic                 frame_done
);

    localparam int N  = ROWS * COLS;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = $clog2(DWELL + BLANK_CYCLES + 1);

`ifdef ROW_BLANK_EN
    typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
`else
    typedef enum logic [1:0] {IDLE, SCAN} state_t;
`endif

    state_t          state, state_d;
    logic [RW-1:0]   row, row_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [N-1:0]    snap, snap_d;
    logic            ack_d, done_d, frame_end;
    logic [ROWS-1:0] row_sel_d;
    logic [COLS-1:0] col_data_d;
    int              base;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            row        <= '0;
            cnt        <= '0;
            snap       <= '0;
            grid_ack   <= 1'b0;
            frame_done <= 1'b0;
            row_sel    <= '0;
            col_data   <= '0;
        end else begin
            state      <= state_d;
            row        <= row_d;
            cnt        <= cnt_d;
            snap       <= snap_d;
            grid_ack   <= ack_d;
            frame_done <= done_d;
            row_sel    <= row_sel_d;
            col_data   <= col_data_d;
        end
    end

    always_comb begin
        state_d    = state;
        row_d      = row;
        cnt_d      = cnt;
        snap_d     = snap;
        ack_d      = 1'b0;
        done_d     = 1'b0;
        frame_end  = 1'b0;
        row_sel_d  = '0;
        col_data_d = '0;
        base       = 0;

        unique case (state)
            IDLE: begin
                if (enable && grid_valid) begin
                    snap_d  = grid_in;
                    ack_d   = 1'b1;
                    state_d = SCAN;
                    row_d   = '0;
                    cnt_d   = '0;
                end
            end
            SCAN: begin
                if (cnt == CW'(DWELL - 1)) begin
                    cnt_d = '0;
`ifdef ROW_BLANK_EN
                    state_d = BLANK;
`else
                    if (row == RW'(ROWS - 1))
                        frame_end = 1'b1;
                    else
                        row_d = row + RW'(1);
`endif
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
`ifdef ROW_BLANK_EN
            BLANK: begin
                if (cnt == CW'(BLANK_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = SCAN;
                    if (row == RW'(ROWS - 1))
                        frame_end = 1'b1;
                    else
                        row_d = row + RW'(1);
                end else begin
                    cnt_d = cnt + CW'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase

        // A pending generation is taken even when enable has dropped.
        if (frame_end) begin
            done_d = 1'b1;
            row_d  = '0;
            cnt_d  = '0;
            if (grid_valid) begin
                snap_d  = grid_in;
                ack_d   = 1'b1;
                state_d = SCAN;
            end else if (enable) begin
                state_d = SCAN;
            end else begin
                state_d = IDLE;
            end
        end

        if (state_d == SCAN) begin
            base       = int'(row_d) * COLS;
            row_sel_d  = ROWS'(1) << row_d;
            col_data_d = snap_d[base +: COLS];
        end
    end

endmodule

// File: tb/tb_gol_grid_scanner.sv
// Self-checking bench for gol_grid_scanner: directed scenarios plus random traffic against a frame-position model.
module tb_gol_grid_scanner;

    localparam int ROWS         = 8;
    localparam int COLS         = 8;
    localparam int DWELL        = 4;
    localparam int BLANK_CYCLES = 1;
`ifdef ROW_BLANK_EN
    localparam int BL = BLANK_CYCLES;
`else
    localparam int BL = 0;
`endif
    localparam int P  = DWELL + BL;
    localparam int FL = ROWS * P;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 enable;
    logic [ROWS*COLS-1:0] grid_in;
    logic                 grid_valid;
    logic                 grid_ack;
    logic [ROWS-1:0]      row_sel;
    logic [COLS-1:0]      col_data;
    logic                 frame_done;

    int n_assert = 0;
    int n_fail   = 0;

    // Model: is a frame running, position within it, displayed snapshot
    bit                   m_active;
    int                   m_pos;
    logic [ROWS*COLS-1:0] m_snap;
    logic                 m_ack;
    logic                 m_done;

    gol_grid_scanner #(
        .ROWS(ROWS), .COLS(COLS), .DWELL(DWELL), .BLANK_CYCLES(BLANK_CYCLES)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .grid_in(grid_in),
        .grid_valid(grid_valid), .grid_ack(grid_ack), .row_sel(row_sel),
        .col_data(col_data), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [ROWS-1:0] exp_row_sel();
        logic [ROWS-1:0] one = 1;
        if (!m_active || (m_pos % P) >= DWELL) return '0;
        return one << (m_pos / P);
    endfunction

    function automatic logic [COLS-1:0] exp_col_data();
        if (!m_active || (m_pos % P) >= DWELL) return '0;
        return m_snap[(m_pos / P) * COLS +: COLS];
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_pos    = 0;
        m_snap   = '0;
        m_ack    = 0;
        m_done   = 0;
    endtask

    task automatic model_step();
        m_ack  = 0;
        m_done = 0;
        if (!m_active) begin
            if (enable && grid_valid) begin
                m_snap   = grid_in;
                m_ack    = 1;
                m_active = 1;
                m_pos    = 0;
            end
        end else begin
            m_pos++;
            if (m_pos == FL) begin
                m_done = 1;
                m_pos  = 0;
                if (grid_valid) begin
                    m_snap = grid_in;
                    m_ack  = 1;
                end else if (!enable) begin
                    m_active = 0;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("row_sel", 64'(row_sel), 64'(exp_row_sel()));
        check("col_data", 64'(col_data), 64'(exp_col_data()));
        check("grid_ack", 64'(grid_ack), 64'(m_ack));
        check("frame_done", 64'(frame_done), 64'(m_done));
        check("onehot", 64'($countones(row_sel) <= 1), 64'(1));
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_step();
        @(negedge clk);
        check_outputs();
        if (grid_ack) grid_valid = 1'b0;
    endtask

    task automatic mid_reset();
        reset      = 1'b1;
        grid_valid = 1'b0;
        #1;
        model_reset();
        check_outputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic wait_done(input string tag, output int k);
        k = 0;
        while (!frame_done && k < 4 * FL) begin
            tick();
            k++;
        end
        check(tag, 64'(frame_done), 64'(1));
    endtask

    initial begin
        int k;
        logic [63:0] g;
        reset      = 1'b1;
        enable     = 1'b0;
        grid_valid = 1'b0;
        grid_in    = '0;
        model_reset();
        #1;
        check_outputs();
        tick();
        reset = 1'b0;

        // Idle with nothing offered
        repeat (20) tick();

        // First capture: diagonal pattern
        grid_in    = 64'h8040201008040201;
        enable     = 1'b1;
        grid_valid = 1'b1;
        tick();
        check("first_ack", 64'(grid_ack), 64'(1));
        check("first_row0", 64'(row_sel), 64'h01);
        check("first_col0", 64'(col_data), 64'h01);
        wait_done("first_done", k);
        check("frame_len", 64'(k), 64'(FL));

        // Mid-frame update offered during row 3
        repeat (3 * P) tick();
        grid_in    = 64'hFF00_0000_0000_0000;
        grid_valid = 1'b1;
        tick();
        wait_done("upd_done", k);
        check("upd_ack_with_done", 64'(grid_ack), 64'(1));
        check("upd_wait", 64'(k), 64'(FL - 3 * P - 1));
        check("upd_row0_dark", 64'(col_data), 64'h00);
        repeat (7 * P) tick();
        check("upd_row7", 64'(col_data), 64'hFF);

        // Repeat, then stop by dropping enable in row 5
        wait_done("rep_done", k);
        repeat (5 * P) tick();
        enable = 1'b0;
        wait_done("stop_done", k);
        check("stop_ack", 64'(grid_ack), 64'(0));
        tick();
        check("stop_idle_row", 64'(row_sel), 64'(0));
        repeat (5) tick();

        // Reset during row 4
        enable     = 1'b1;
        grid_in    = {$urandom, $urandom};
        grid_valid = 1'b1;
        tick();
        repeat (4 * P) tick();
        mid_reset();
        repeat (10) tick();
        check("post_reset_idle", 64'(row_sel), 64'(0));

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            if (!grid_valid && $urandom_range(0, 19) == 0) begin
                g          = {$urandom, $urandom};
                grid_in    = g;
                grid_valid = 1'b1;
            end
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 399) == 0) mid_reset();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
